// File: rtl/mips_mem_responder.sv
// mips_mem_responder: single-outstanding LW/SW memory responder with a fixed number of wait states.
// The memory is accessed on the edge that enters RESP, and that result is held until the response handshake.
module mips_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int AW          = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [3:0] LP_WLOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic        r_we, r_err;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [31:0] r_mem [DEPTH];
    logic        w_accept, w_enter, w_we, w_oor;
    logic [31:0] w_addr, w_wdata;
    assign w_accept = req_valid && (r_state == IDLE);
    // With no wait states the access happens on the accepting edge, so use the live request
    assign w_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
    assign w_oor   = |w_addr[31:AW];
    assign w_enter = (w_accept && WAIT_CYCLES == 0) || (r_state == WAIT && r_cnt == 4'd0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? ((WAIT_CYCLES == 0) ? RESP : WAIT) : IDLE;
            WAIT:    w_next = (r_cnt == 4'd0) ? RESP : WAIT;
            RESP:    w_next = rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        req_ready = (r_state == IDLE);
        rsp_valid = (r_state == RESP);
        rsp_rdata = r_rdata;
        rsp_err   = r_err;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= LP_WLOAD;
            end else if (r_state == WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter) begin
                r_rdata <= (w_we || w_oor) ? '0 : r_mem[w_addr[AW-1:0]];
                r_err   <= w_oor;
            end
        end
    end
    // Storage is deliberately not reset; the rst_n gate blocks commits while reset is held
    always_ff @(posedge clk) begin
        if (rst_n && w_enter && w_we && !w_oor) r_mem[w_addr[AW-1:0]] <= w_wdata;
    end
endmodule

// File: tb/tb_mips_mem_responder.sv
// tb_mips_mem_responder: scoreboard bench for mips_mem_responder.
// Instance a uses two wait states, instance b uses none for the throughput run.
module tb_mips_mem_responder;
    typedef struct packed {logic [31:0] d; logic e;} exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic a_req_valid = 1'b0, a_req_we = 1'b0, a_rsp_ready = 1'b0;
    logic [31:0] a_req_addr = '0, a_req_wdata = '0;
    logic a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic b_req_valid = 1'b0, b_req_we = 1'b0, b_rsp_ready = 1'b0;
    logic [31:0] b_req_addr = '0, b_req_wdata = '0;
    logic b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;
    exp_t qa[$], qb[$];
    logic [31:0] model_a [int];
    logic [31:0] model_b [int];
    int n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    mips_mem_responder #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );
    mips_mem_responder #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model_a_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t x;
        logic oor = |addr[31:10];
        int idx = int'(addr[9:0]);
        x.e = oor;
        x.d = (we || oor) ? 32'h0 : model_a[idx];
        if (we && !oor) model_a[idx] = wdata;
        return x;
    endfunction

    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        exp_t x;
        int lat;
        logic [31:0] held_d;
        logic held_e;
        qa.push_back(model_a_access(we, addr, wdata));
        a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_valid = 1'b1;
        chk("req_ready_idle", 32'(a_req_ready), 32'd1);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        lat = 1;
        while (!a_rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'd3);
        x = qa.pop_front();
        chk("rdata", a_rsp_rdata, x.d);
        chk("err", 32'(a_rsp_err), 32'(x.e));
        held_d = a_rsp_rdata;
        held_e = a_rsp_err;
        for (int i = 0; i < hold; i++) begin
            a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h9; a_req_wdata = 32'hFFFF_FFFF;
            @(posedge clk); #1;
            chk("hold_valid", 32'(a_rsp_valid), 32'd1);
            chk("hold_rdata", a_rsp_rdata, held_d);
            chk("hold_err", 32'(a_rsp_err), 32'(held_e));
            chk("hold_ready", 32'(a_req_ready), 32'd0);
        end
        a_req_valid = 1'b0;
        a_rsp_ready = 1'b1;
        @(posedge clk); #1;
        a_rsp_ready = 1'b0;
        chk("rsp_cleared", 32'(a_rsp_valid), 32'd0);
        chk("back_idle", 32'(a_req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] ra, rd;
        logic bwe [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] baddr [4] = '{32'h1, 32'h2, 32'h1, 32'h2};
        logic [31:0] bdata [4] = '{32'hA1, 32'hB2, 32'h0, 32'h0};
        exp_t x;
        int k, n_rsp;
        logic acc;
        #2 rst_n = 1'b0;
        #3;
        chk("rst_req_ready", 32'(a_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_rdata", a_rsp_rdata, 32'd0);
        chk("rst_err", 32'(a_rsp_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        xact(1'b1, 32'h5, 32'hDEAD_BEEF, 0);
        xact(1'b0, 32'h5, 32'h0, 0);
        xact(1'b1, 32'h3, 32'h3333_3333, 0);
        xact(1'b1, 32'h9, 32'h0000_0099, 0);
        xact(1'b0, 32'h0000_0400, 32'h0, 0);
        xact(1'b1, 32'h0001_0003, 32'h0000_0BAD, 0);
        xact(1'b0, 32'h3, 32'h0, 5);
        xact(1'b1, 32'h7, 32'hA5A5_A5A5, 0);
        xact(1'b0, 32'h7, 32'h0, 0);
        // store that reset aborts one cycle after acceptance
        a_req_we = 1'b1; a_req_addr = 32'h7; a_req_wdata = 32'h1234; a_req_valid = 1'b1;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst_req_ready", 32'(a_req_ready), 32'd1);
        chk("arst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("arst_rdata", a_rsp_rdata, 32'd0);
        chk("arst_err", 32'(a_rsp_err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        xact(1'b0, 32'h7, 32'h0, 0);
        for (int j = 0; j < 4; j++) begin
            ra = 32'($urandom_range(16, 1023));
            rd = $urandom;
            xact(1'b1, ra, rd, 0);
            xact(1'b0, ra, 32'h0, j);
        end
        xact(1'b0, 32'h9, 32'h0, 0);
        // zero-wait instance: request held valid, response always ready
        b_rsp_ready = 1'b1;
        k = 0;
        n_rsp = 0;
        b_req_we = bwe[0]; b_req_addr = baddr[0]; b_req_wdata = bdata[0]; b_req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("b_req_ready", 32'(b_req_ready), 32'((i % 2) == 0));
            if (b_rsp_valid) begin
                n_rsp++;
                if (qb.size() == 0) chk("b_unexpected_rsp", 32'd1, 32'd0);
                else begin
                    x = qb.pop_front();
                    chk("b_rdata", b_rsp_rdata, x.d);
                    chk("b_err", 32'(b_rsp_err), 32'(x.e));
                end
            end
            acc = b_req_ready && b_req_valid;
            if (acc) begin
                x.e = 1'b0;
                x.d = bwe[k] ? 32'h0 : model_b[int'(baddr[k])];
                if (bwe[k]) model_b[int'(baddr[k])] = bdata[k];
                qb.push_back(x);
            end
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k < 4) begin
                    b_req_we = bwe[k]; b_req_addr = baddr[k]; b_req_wdata = bdata[k];
                end else b_req_valid = 1'b0;
            end
        end
        chk("b_rsp_count", 32'(n_rsp), 32'd4);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
